// File: rtl/sysid_info_regs.sv
// System-identification and housekeeping register block on an Avalon-MM slave port.
// Read data is captured at the acceptance edge and delivered READ_LATENCY edges later.
module sysid_info_regs #(
    parameter logic [31:0]  SYS_ID          = 32'h0000_0000,
    parameter logic [31:0]  BUILD_TIMESTAMP = 32'd1584165023,
    parameter int           HASH_WORDS      = 2,
    parameter logic [255:0] BUILD_HASH      = 256'h0,
    parameter int           READ_LATENCY    = 1,
    parameter int           UPTIME_DIV      = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [31:0] PRESC_LAST = 32'(UPTIME_DIV - 1);
    localparam logic [31:0] CAPS = {26'd0,
                                    (UPTIME_DIV == 1) ? 1'b1 : 1'b0,
                                    (READ_LATENCY == 2) ? 1'b1 : 1'b0,
                                    4'(HASH_WORDS)};

    logic [63:0] cyc_reg;
    logic [31:0] shadow_hi_reg;
    logic [31:0] scratch_reg;
    logic [31:0] presc_reg;
    logic [31:0] uptime_reg;
    logic [31:0] rd_data_next;
    logic [31:0] hash_word [8];
    logic [31:0] pipe_data_reg [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid_reg;

    logic wr_scratch;
    logic clr_uptime;
    logic snap_hi;
    logic presc_tc;

    assign wr_scratch = write && (address == 4'd2);
    assign clr_uptime = write && (address == 4'd6) && (|byteenable);
    assign snap_hi    = read && (address == 4'd4);
    assign presc_tc   = (presc_reg == PRESC_LAST);

    // Hash words beyond HASH_WORDS read as zero regardless of BUILD_HASH contents.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hash
            if (gi < HASH_WORDS) begin : g_valid
                assign hash_word[gi] = BUILD_HASH[32*gi +: 32];
            end else begin : g_zero
                assign hash_word[gi] = 32'd0;
            end
        end
    endgenerate

    always_comb begin
        rd_data_next = 32'd0;
        case (address)
            4'd0: rd_data_next = SYS_ID;
            4'd1: rd_data_next = BUILD_TIMESTAMP;
            4'd2: rd_data_next = scratch_reg;
            4'd3: rd_data_next = CAPS;
            4'd4: rd_data_next = cyc_reg[31:0];
            4'd5: rd_data_next = shadow_hi_reg;
            4'd6: rd_data_next = uptime_reg;
            4'd7: rd_data_next = 32'd0;
            default: rd_data_next = hash_word[address[2:0]];
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_reg       <= 64'd0;
            shadow_hi_reg <= 32'd0;
            scratch_reg   <= 32'd0;
            presc_reg     <= 32'd0;
            uptime_reg    <= 32'd0;
        end else begin
            cyc_reg <= cyc_reg + 64'd1;
            if (snap_hi) begin
                shadow_hi_reg <= cyc_reg[63:32];
            end
            for (int b = 0; b < 4; b++) begin
                if (wr_scratch && byteenable[b]) begin
                    scratch_reg[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
            // A software clear takes priority over a coincident prescaler tick.
            if (clr_uptime) begin
                presc_reg  <= 32'd0;
                uptime_reg <= 32'd0;
            end else if (presc_tc) begin
                presc_reg  <= 32'd0;
                uptime_reg <= uptime_reg + 32'd1;
            end else begin
                presc_reg  <= presc_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid_reg <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data_reg[i] <= 32'd0;
            end
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            pipe_valid_reg[0] <= read;
            pipe_data_reg[0]  <= rd_data_next;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_data_reg[i]  <= pipe_data_reg[i-1];
            end
            readdatavalid <= pipe_valid_reg[READ_LATENCY-1];
            if (pipe_valid_reg[READ_LATENCY-1]) begin
                readdata <= pipe_data_reg[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: doc/sysid_info_regs.md
# sysid_info_regs

Parametrised system-identification and housekeeping register block on the Avalon-MM control fabric; supersedes the fixed two-word ID/timestamp slave. Exposes the ID, build timestamp, a capability word, a multi-word build hash, a byte-writable scratch register, a free-running 64-bit cycle counter with atomic high-word snapshot, and a prescaled uptime counter. Software reads it at boot to confirm it has the right bitstream, and at runtime for coarse timekeeping.

## Interface
- SYS_ID, 32'h0000_0000: value of the ID register.
- BUILD_TIMESTAMP, 32'd1584165023: value of the TIMESTAMP register, in Unix seconds.
- HASH_WORDS, 2: number of valid build-hash words. Range 0..8.
- BUILD_HASH, 256'h0: hash words. Word k is BUILD_HASH[32k+31:32k].
- READ_LATENCY, 1: cycles from read acceptance to readdatavalid. Legal values are 1 and 2.
- UPTIME_DIV, 50000000: clock cycles per uptime tick. Minimum 1.
- clock, in, 1: sole clock.
- reset_n, in, 1: asynchronous assert, active-low reset.
- address, in, 4: word address.
- read, in, 1: read request. Accepted every cycle it is high; there is no waitrequest.
- write, in, 1: write request. Accepted every cycle it is high.
- writedata, in, 32: write data.
- byteenable, in, 4: byte lanes for writes.
- readdata, out, 32: read data. Registered.
- readdatavalid, out, 1: one-cycle pulse for each accepted read.

## Operation
Register map (word address, access, contents):
- 0, RO: SYS_ID.
- 1, RO: BUILD_TIMESTAMP.
- 2, RW: SCRATCH. Honours byteenable per byte. Reset value 0.
- 3, RO: CAPS.
  - [3:0] = HASH_WORDS.
  - [4] = READ_LATENCY-1.
  - [5] = 1 when UPTIME_DIV==1.
  - All other bits 0.
- 4, RO: CYCLE_LO.
  - Returns cyc[31:0] as it stands in the acceptance cycle.
  - In the same cycle, loads shadow_hi with cyc[63:32].
- 5, RO: CYCLE_HI. Returns shadow_hi. Reading it does not alter state.
- 6, RW: UPTIME. Returns the 32-bit tick count.
  - A write with any byteenable bit set clears both the uptime count and the prescaler to 0. writedata is ignored.
- 7, RO: reads 0.
- 8..15, RO: hash word (address-8) while address-8 < HASH_WORDS; otherwise 0.

Write and side-effect rules:
- Writes to RO addresses are ignored.
- Reads have no side effects except address 4.

Counters:
- cyc increments every cycle. Wraps 2^64-1 -> 0.
- The prescaler counts 0..UPTIME_DIV-1. On the terminal count it returns to 0 and uptime increments. uptime wraps 2^32-1 -> 0.

Simultaneous events:
- read and write in the same cycle: both are performed. The read returns the pre-write value.
- A write that clears UPTIME in the same cycle the prescaler hits terminal count: the clear wins, and uptime becomes 0.

Reset values: readdata=0, readdatavalid=0, SCRATCH=0, cyc=0, shadow_hi=0, prescaler=0, uptime=0.

## Timing
Read pipeline:
- A read accepted at edge N produces readdatavalid=1 with the data after edge N+READ_LATENCY.
- The pipeline is fully pipelined: back-to-back reads yield back-to-back valids, in order.

Read data capture:
- Data is the register value sampled at acceptance edge N, not at edge N+READ_LATENCY.
- CYCLE_LO read at edge N returns the pre-increment value present before edge N.
- shadow_hi is updated at edge N.

Hold and write behaviour:
- readdata holds its last value while readdatavalid=0.
- A write takes effect at its acceptance edge. A read accepted at the next edge sees the new value.

Reset:
- reset_n low mid-pipeline immediately clears all in-flight valids and every register. No stale readdatavalid follows deassertion.
- After deassertion, cyc reads 0 on the first accepted CYCLE_LO if that read is accepted at the first edge.

## Test plan
- **ID/timestamp/caps.**
  - Stimulus: defaults; read addresses 0, 1, 3, 7.
  - Required response: 0, 1584165023, 32'h0000_0002, 0, each with readdatavalid exactly 1 cycle after acceptance.
  - Repeat with READ_LATENCY=2: CAPS[4]=1 and valid 2 cycles after acceptance.
- **Hash bounds.**
  - Stimulus: HASH_WORDS=3, BUILD_HASH words 0xA0,0xA1,0xA2.
  - Required response: reads of 8, 9, 10 return those words; reads of 11 and 15 return 0.
- **Scratch byte lanes.**
  - Stimulus: write 0x11223344 with byteenable 4'hF, then write 0xAABBCCDD with byteenable 4'b0101.
  - Required response: reads 0x11BB33DD.
  - Stimulus: a same-cycle read+write to address 2.
  - Required response: the read returns the prior value.
- **Atomic 64-bit read.**
  - Stimulus: force cyc to 0x0000_0000_FFFF_FFFE, then read 4 and then 5 three cycles later.
  - Required response: LO=0xFFFF_FFFE, HI=0 (the snapshot, not the live value 1).
  - Stimulus: read 5 again.
  - Required response: still 0.
- **Uptime.**
  - Stimulus: UPTIME_DIV=4; run 13 cycles after reset.
  - Required response: UPTIME reads 3.
  - Stimulus: write address 6 coincident with the terminal count.
  - Required response: the next read returns 0, and the next increment arrives exactly 4 cycles later.
- **Reset mid-operation.**
  - Stimulus: issue 3 back-to-back reads, then pull reset_n low asynchronously between edges while valids are pending.
  - Required response: readdatavalid and readdata go 0 immediately and no valid appears after release; SCRATCH, cyc and uptime read 0.
